// File: rtl/timer_display.sv
// rtl/timer_display.sv - 4-digit multiplexed 7-segment decimal readout of the timer count (optional blink: TIMER_DISPLAY_BLINK_EN)
module timer_display #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int REFRESH_WIDTH  = 17,
  parameter int BLINK_CYCLES   = 25000000,
  parameter int BLINK_WIDTH    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] count,
  input  logic        done,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                   state;
  logic [15:0]              sampled;
  logic [31:0]              sr;
  logic [3:0]               iter;
  logic [15:0]              digits;
  logic                     ovf;

  logic [REFRESH_WIDTH-1:0] rcnt;
  logic [1:0]               sel;
  logic                     armed;

  logic                     wrap;
  logic [1:0]               sel_next;
  logic [3:0]               nib;
  logic [6:0]               seg_next;
  logic [3:0]               an_scan;
  logic                     dp_next;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low segment pattern for one decimal digit; anything above 9 is blanked.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Binary-to-BCD converter: sample a changed count, 16 shift-add-3 steps, then load the digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sampled <= 16'd0;
      sr      <= 32'd0;
      iter    <= 4'd0;
      digits  <= 16'd0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != sampled) begin
            sampled <= count;
            sr      <= {16'd0, count};
            iter    <= 4'd0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sr   <= {add3(sr[31:16]), sr[15:0]} << 1;
          iter <= iter + 4'd1;
          if (iter == 4'd15) state <= LOAD;
        end
        LOAD: begin
          // Only four BCD digits are kept; the ten-thousands digit has been shifted out.
          digits <= sr[31:16];
          ovf    <= (sampled > 16'd9999);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next digit select and the display values for that slot.
  always_comb begin
    wrap     = (rcnt == REFRESH_WIDTH'(REFRESH_CYCLES - 1));
    sel_next = (wrap && armed) ? sel + 2'd1 : sel;
    case (sel_next)
      2'd0:    nib = digits[3:0];
      2'd1:    nib = digits[7:4];
      2'd2:    nib = digits[11:8];
      default: nib = digits[15:12];
    endcase
    seg_next = ovf ? SEG_DASH : seg_code(nib);
    an_scan  = ~(4'b0001 << sel_next);
    dp_next  = ~((sel_next == 2'd0) && done);
  end

`ifdef TIMER_DISPLAY_BLINK_EN
  logic [BLINK_WIDTH-1:0] bcnt;
  logic                   phase_on;
  logic                   bwrap;
  logic                   phase_next;
  logic                   blank_next;

  // Blink phase runs only while done is high and snaps back to "on" as soon as done drops.
  always_comb begin
    bwrap = (bcnt == BLINK_WIDTH'(BLINK_CYCLES - 1));
    if (!done)      phase_next = 1'b1;
    else if (bwrap) phase_next = ~phase_on;
    else            phase_next = phase_on;
    blank_next = done && !phase_next;
  end

  // Blink half-period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else begin
      phase_on <= phase_next;
      if (!done || bwrap) bcnt <= '0;
      else                bcnt <= bcnt + BLINK_WIDTH'(1);
    end
  end
`else
  localparam int unused_blink_params = BLINK_CYCLES + BLINK_WIDTH;
`endif

  // Refresh divider and registered display drivers; the first slot after reset shows the units digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt  <= '0;
      sel   <= 2'd0;
      armed <= 1'b0;
      an    <= 4'b1111;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      if (wrap) begin
        rcnt  <= '0;
        sel   <= sel_next;
        armed <= 1'b1;
        seg   <= seg_next;
        dp    <= dp_next;
      end else begin
        rcnt <= rcnt + REFRESH_WIDTH'(1);
      end
`ifdef TIMER_DISPLAY_BLINK_EN
      // Anodes track the blink phase every clock once scanning has started.
      if (wrap || armed) an <= blank_next ? 4'b1111 : an_scan;
`else
      if (wrap) an <= an_scan;
`endif
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// tb/tb_timer_display.sv - self-checking bench for timer_display
module tb_timer_display;

  localparam int RC = 4;
  localparam int RW = 3;
  localparam int BC = 8;
  localparam int BW = 4;
`ifdef TIMER_DISPLAY_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] count = 16'd0;
  logic        done = 1'b1;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  timer_display #(
    .REFRESH_CYCLES(RC),
    .REFRESH_WIDTH (RW),
    .BLINK_CYCLES  (BC),
    .BLINK_WIDTH   (BW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .count(count),
    .done (done),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      count;
    logic             done;
    logic [3:0][6:0]  seg_exp;
  } vec_t;

  vec_t tab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] seg_of_digit(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return t[d];
  endfunction

  function automatic logic [3:0][6:0] model_segs(input int cnt);
    logic [3:0][6:0] r;
    int v;
    v = cnt;
    for (int i = 0; i < 4; i++) begin
      r[i] = (cnt > 9999) ? 7'b0111111 : seg_of_digit(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] model_bcd(input int cnt);
    int v;
    v = cnt % 10000;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Watch 16 clocks (four full slots) and compare every lit slot with the expected digit.
  task automatic scan_check(input string tag, input logic [3:0][6:0] exp, input logic dn);
    int idx;
    for (int i = 0; i < 16; i++) begin
      step();
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        if (!(BLINK && dn && an == 4'b1111)) begin
          checks++;
          errors++;
          $display("FAIL %s an: got %b expected one digit enabled", tag, an);
        end
      end else begin
        chk({tag, " seg"}, 32'(seg), 32'(exp[idx]));
        chk({tag, " dp"}, 32'(dp), (idx == 0 && dn) ? 32'd0 : 32'd1);
      end
    end
  endtask

  initial begin
    int cnt;
    int slot;
    int blanks;
    logic [3:0] ea;

    tab[0] = '{16'd0,     1'b1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    tab[1] = '{16'd1234,  1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tab[2] = '{16'd10000, 1'b0, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
    tab[3] = '{16'd9999,  1'b0, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}};
    tab[4] = '{16'd7,     1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}};
    tab[5] = '{16'd65535, 1'b0, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};
    tab[6] = '{16'd5060,  1'b0, {7'b0010010, 7'b1000000, 7'b0000010, 7'b1000000}};
    tab[7] = '{16'd8,     1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0000000}};

    // Reset values
    rst = 1'b1; count = 16'd0; done = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset an", 32'(an), 32'hF);
    chk("reset seg", 32'(seg), 32'h7F);
    chk("reset dp", 32'(dp), 32'd1);
    chk("reset digits", 32'(dut.digits), 32'd0);
    rst = 1'b0;

    // First slot after RC clocks, then units..thousands every RC clocks
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k < RC) begin
        ea = 4'b1111;
        chk("startup seg", 32'(seg), 32'h7F);
        chk("startup dp", 32'(dp), 32'd1);
      end else begin
        slot = (k / RC - 1) % 4;
        ea = ~(4'b0001 << slot);
        if (BLINK && ((k / BC) % 2 == 1)) ea = 4'b1111;
        chk("startup seg", 32'(seg), 32'h40);
        chk("startup dp", 32'(dp), (slot == 0) ? 32'd0 : 32'd1);
      end
      chk("startup an", 32'(an), 32'(ea));
    end

    // Table-driven display vectors
    for (int i = 0; i < 8; i++) begin
      count = tab[i].count;
      done  = tab[i].done;
      repeat (40) step();
      scan_check($sformatf("table%0d", i), tab[i].seg_exp, tab[i].done);
    end

    // Conversion latency: digits load at E17, not E16
    count = 16'd1234;
    for (int e = 0; e <= 17; e++) begin
      step();
      if (e == 16) chk("latency E16", 32'(dut.digits), 32'h0008);
      if (e == 17) chk("latency E17", 32'(dut.digits), 32'h1234);
    end
    repeat (10) step();
    scan_check("latency scan", model_segs(1234), 1'b0);

    // Changes during a conversion are picked up afterwards
    count = 16'd30;
    repeat (40) step();
    count = 16'd29;
    for (int e = 0; e <= 35; e++) begin
      step();
      if (e == 4) count = 16'd28;
      if (e == 17) chk("busy E17", 32'(dut.digits), 32'h0029);
      if (e == 34) chk("busy E34", 32'(dut.digits), 32'h0029);
      if (e == 35) chk("busy E35", 32'(dut.digits), 32'h0028);
    end
    repeat (10) step();
    scan_check("busy scan", model_segs(28), 1'b0);

    // Asynchronous reset in the middle of a conversion
    count = 16'd0;
    repeat (40) step();
    count = 16'd4321;
    for (int e = 0; e <= 8; e++) step();
    rst = 1'b1;
    #1;
    chk("midreset an", 32'(an), 32'hF);
    chk("midreset seg", 32'(seg), 32'h7F);
    chk("midreset dp", 32'(dp), 32'd1);
    @(negedge clk);
    chk("midreset digits", 32'(dut.digits), 32'd0);
    rst = 1'b0;
    repeat (40) step();
    chk("reconvert digits", 32'(dut.digits), 32'(model_bcd(4321)));
    scan_check("reconvert scan", model_segs(4321), 1'b0);

    // Randomized counts against the decimal model
    for (int r = 0; r < 10; r++) begin
      cnt = $urandom_range(0, 65535);
      if ($urandom_range(0, 3) != 0) cnt = $urandom_range(0, 9999);
      count = 16'(cnt);
      done  = (cnt == 0);
      repeat (40) step();
      chk($sformatf("rand%0d digits", r), 32'(dut.digits), 32'(model_bcd(cnt)));
      scan_check($sformatf("rand%0d", r), model_segs(cnt), done);
    end

    // Done handling: blink (if built in) and immediate resume when done drops
    count = 16'd0;
    done  = 1'b1;
    repeat (40) step();
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (an == 4'b1111) blanks++;
    end
    chk("done blank count", 32'(blanks), BLINK ? 32'd16 : 32'd0);
    done = 1'b0;
    step();
    chk("done fall resume", 32'(an == 4'b1111), 32'd0);
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (an == 4'b1111) blanks++;
    end
    chk("not done blank count", 32'(blanks), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
